// File: rtl/universal_shift_reg_n_if.sv
// Command/data bundle for universal_shift_reg_n: command handshake in, register state out.
// master drives commands; slave is the shift register.
interface universal_shift_reg_n_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_mode, cmd_amt, d, sin,
        input  cmd_ready, q, sout, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_amt, d, sin,
        output cmd_ready, q, sout, busy, done
    );
endinterface

// File: rtl/universal_shift_reg_n.sv
// Universal N-bit shift register: load/shift/rotate/clear, multi-bit shifts one bit per cycle.
// Latency: 1 cycle for NOP/LOAD/CLEAR/amt=0, else accept edge plus amt shift cycles.
// Backpressure: cmd_ready = ~busy; commands offered while busy are ignored.
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    universal_shift_reg_n_if.slave bus
);
    localparam logic [2:0] MODE_NOP   = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic [2:0]       mode_r, mode_n;
    logic [WIDTH-1:0] q_r, q_n, step_q;
    logic             sout_r, sout_n, step_sout;
    logic             done_r, done_n;
    logic             accept;

    assign accept        = bus.cmd_valid && (state == IDLE);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state == SHIFT);
    assign bus.q         = q_r;
    assign bus.sout      = sout_r;
    assign bus.done      = done_r;

    // One 1-bit step of the latched mode; sin is sampled live every shift cycle.
    always_comb begin
        step_q    = q_r;
        step_sout = sout_r;
        case (mode_r)
            MODE_SHR: begin step_q = {bus.sin, q_r[WIDTH-1:1]};      step_sout = q_r[0];       end
            MODE_SHL: begin step_q = {q_r[WIDTH-2:0], bus.sin};      step_sout = q_r[WIDTH-1]; end
            MODE_ROR: begin step_q = {q_r[0], q_r[WIDTH-1:1]};       step_sout = q_r[0];       end
            MODE_ROL: begin step_q = {q_r[WIDTH-2:0], q_r[WIDTH-1]}; step_sout = q_r[WIDTH-1]; end
            MODE_ASR: begin step_q = {q_r[WIDTH-1], q_r[WIDTH-1:1]}; step_sout = q_r[0];       end
            default:  begin step_q = q_r;                            step_sout = sout_r;       end
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_r;
        q_n     = q_r;
        sout_n  = sout_r;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    mode_n = bus.cmd_mode;
                    case (bus.cmd_mode)
                        MODE_NOP:   done_n = 1'b1;
                        MODE_LOAD:  begin q_n = bus.d; done_n = 1'b1; end
                        MODE_CLEAR: begin q_n = '0;    done_n = 1'b1; end
                        default: begin
                            if (bus.cmd_amt == '0) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = SHIFT;
                                cnt_n   = bus.cmd_amt;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                q_n    = step_q;
                sout_n = step_sout;
                cnt_n  = cnt - 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_r <= MODE_NOP;
            q_r    <= '0;
            sout_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            q_r    <= q_n;
            sout_r <= sout_n;
            done_r <= done_n;
        end
    end
endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Bench for universal_shift_reg_n: directed table, busy/reset corner cases, random vs closed-form model.
module tb_universal_shift_reg_n;
    localparam int W  = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    universal_shift_reg_n_if #(.WIDTH(W), .AMT_W(AW)) bus ();
    universal_shift_reg_n #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        int         amt;
        logic [7:0] d;
        bit         sin;
        logic [7:0] exp_q;
        bit         exp_sout;
        int         exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Closed-form result of a whole command: returns {sout, q}.
    function automatic logic [8:0] ref_op(input logic [2:0] mode, input int amt,
                                          input logic [7:0] dv, input bit s,
                                          input logic [7:0] q, input bit so);
        logic [15:0] ext;
        int c;
        c = (amt > W) ? W : amt;
        if (mode == 3'd0) return {so, q};
        if (mode == 3'd3) return {so, dv};
        if (mode == 3'd7) return {so, 8'h00};
        if (amt == 0)     return {so, q};
        case (mode)
            3'd1: begin ext = {{8{s}}, q} >> c;    return {(amt <= W) ? q[amt-1] : s, ext[7:0]}; end
            3'd6: begin ext = {{8{q[7]}}, q} >> c; return {(amt <= W) ? q[amt-1] : q[7], ext[7:0]}; end
            3'd2: begin ext = {q, {8{s}}} << c;    return {(amt <= W) ? q[W-amt] : s, ext[15:8]}; end
            3'd4: begin ext = {q, q} >> (amt % W); return {q[(amt-1) % W], ext[7:0]}; end
            default: begin ext = {q, q} << (amt % W); return {q[W-1-((amt-1) % W)], ext[15:8]}; end
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] mode, input int amt, input logic [7:0] dv,
                           input bit s, output int bcnt, output bit dseen);
        @(negedge clk);
        check("ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_amt   = amt[AW-1:0];
        bus.d         = dv;
        bus.sin       = s;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bcnt  = 0;
        dseen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                dseen = 1'b1;
                break;
            end
            if (bus.busy) bcnt++;
            @(negedge clk);
        end
    endtask

    vec_t       vecs[12];
    logic [7:0] mq;
    bit         msout;
    logic [8:0] r;
    int         bc;
    bit         ds;
    bit         spurious;

    initial begin
        vecs[0]  = '{3'd3, 0, 8'hA5, 1'b0, 8'hA5, 1'b0, 0};
        vecs[1]  = '{3'd2, 3, 8'h00, 1'b0, 8'h28, 1'b1, 3};
        vecs[2]  = '{3'd3, 0, 8'h3C, 1'b0, 8'h3C, 1'b1, 0};
        vecs[3]  = '{3'd4, 4, 8'h00, 1'b0, 8'hC3, 1'b1, 4};
        vecs[4]  = '{3'd5, 9, 8'h00, 1'b0, 8'h87, 1'b1, 9};
        vecs[5]  = '{3'd3, 0, 8'h84, 1'b0, 8'h84, 1'b1, 0};
        vecs[6]  = '{3'd6, 2, 8'h00, 1'b0, 8'hE1, 1'b0, 2};
        vecs[7]  = '{3'd1, 7, 8'h00, 1'b1, 8'hFF, 1'b1, 7};
        vecs[8]  = '{3'd1, 0, 8'h00, 1'b0, 8'hFF, 1'b1, 0};
        vecs[9]  = '{3'd0, 5, 8'h12, 1'b0, 8'hFF, 1'b1, 0};
        vecs[10] = '{3'd7, 0, 8'h00, 1'b0, 8'h00, 1'b1, 0};
        vecs[11] = '{3'd4, 0, 8'h00, 1'b1, 8'h00, 1'b1, 0};

        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 3'd0;
        bus.cmd_amt   = '0;
        bus.d         = '0;
        bus.sin       = 1'b0;
        repeat (2) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 3'd3;
        bus.d         = 8'hFF;
        @(negedge clk);
        check("rst_q",    {24'd0, bus.q}, 32'h0);
        check("rst_sout", {31'd0, bus.sout}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].mode, vecs[i].amt, vecs[i].d, vecs[i].sin, bc, ds);
            check($sformatf("vec%0d_done", i), {31'd0, ds}, 32'd1);
            check($sformatf("vec%0d_q", i), {24'd0, bus.q}, {24'd0, vecs[i].exp_q});
            check($sformatf("vec%0d_sout", i), {31'd0, bus.sout}, {31'd0, vecs[i].exp_sout});
            check($sformatf("vec%0d_busy", i), bc, vecs[i].exp_busy);
            check($sformatf("vec%0d_ready_at_done", i), {31'd0, bus.cmd_ready}, 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), {31'd0, bus.done}, 32'd0);
        end

        // Command offered while busy must be ignored.
        run_cmd(3'd3, 0, 8'h77, 1'b0, bc, ds);
        mq = 8'h77;
        msout = bus.sout;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 3'd4;
        bus.cmd_amt   = 4'd3;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_mode = 3'd3;
        bus.d        = 8'hFF;
        check("busy_not_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        ds = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                ds = 1'b1;
                break;
            end
            @(negedge clk);
        end
        r = ref_op(3'd4, 3, 8'h00, 1'b0, mq, msout);
        check("busy_ign_done", {31'd0, ds}, 32'd1);
        check("busy_ign_q", {24'd0, bus.q}, {24'd0, r[7:0]});
        check("busy_ign_sout", {31'd0, bus.sout}, {31'd0, r[8]});

        // Reset in the 2nd cycle of a 5-step shift aborts it without a done pulse.
        run_cmd(3'd3, 0, 8'h5A, 1'b0, bc, ds);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 3'd2;
        bus.cmd_amt   = 4'd5;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_q",    {24'd0, bus.q}, 32'h0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) spurious = 1'b1;
        end
        check("midrst_no_done", {31'd0, spurious}, 32'd0);
        run_cmd(3'd3, 0, 8'hC9, 1'b0, bc, ds);
        check("post_rst_load", {24'd0, bus.q}, 32'hC9);

        // Random commands against the closed-form model.
        mq = bus.q;
        msout = bus.sout;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] m;
            int         a;
            logic [7:0] dv;
            bit         s;
            int         eb;
            m  = 3'($urandom_range(7, 0));
            a  = $urandom_range(15, 0);
            dv = 8'($urandom);
            s  = 1'($urandom);
            r  = ref_op(m, a, dv, s, mq, msout);
            eb = (m == 3'd0 || m == 3'd3 || m == 3'd7) ? 0 : a;
            run_cmd(m, a, dv, s, bc, ds);
            check($sformatf("rnd%0d_m%0d_a%0d_done", i, m, a), {31'd0, ds}, 32'd1);
            check($sformatf("rnd%0d_m%0d_a%0d_q", i, m, a), {24'd0, bus.q}, {24'd0, r[7:0]});
            check($sformatf("rnd%0d_m%0d_a%0d_sout", i, m, a), {31'd0, bus.sout}, {31'd0, r[8]});
            check($sformatf("rnd%0d_m%0d_a%0d_busy", i, m, a), bc, eb);
            mq = r[7:0];
            msout = r[8];
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
